l4_feature_reader: RTL
======================

L4_FEATURE_READER -- requirements
Module: l4_feature_reader

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH, 12, feature word width.
REQ-002 SHALL have parameters: CHANNEL_SIZE, 25, pooled 5x5 words per channel; BANK_DEPTH, 200, words per L4 output bank (8 channels).
REQ-003 SHALL have parameters: READ_LATENCY, 2, L4 output memory address-to-data cycles; FIFO_DEPTH, 4, output buffer entries (power of 2, >= READ_LATENCY+1).
REQ-004 SHALL have ports: clk, in, 1, single clock, rising edge.
REQ-005 SHALL have ports: rst, in, 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: L4_en, in, 1, level enable/start for layer-4 readout.
REQ-007 SHALL have ports: L4_output_read_addr, out, 8, shared read address to both L4 output banks.
REQ-008 SHALL have ports: L4_output_read_data1 / L4_output_read_data2, in, DATA_WIDTH each, bank 1 (channels 0-7) / bank 2 (channels 8-15) read data.
REQ-009 SHALL have ports: feat_valid, out, 1; feat_ready, in, 1; feat_data, out, DATA_WIDTH; feat_index, out, 9, flattened index 0..399 of feat_data.
REQ-010 SHALL have ports: L4_done, out, 1, high while in DONE.

Function
REQ-011 SHALL implement FSM states IDLE, READ, DRAIN, DONE (one-hot): IDLE->READ when L4_en=1; READ->DRAIN after the 400th read is issued; DRAIN->DONE when the 400th beat is accepted; DONE->IDLE when L4_en=0.
REQ-012 SHALL abort to IDLE on L4_en=0 in READ or DRAIN, flushing FIFO and read pipeline; feat_valid low from the next cycle.
REQ-013 SHALL issue reads in order: phase A addr 0..199 selecting data1, then phase B addr 0..199 selecting data2; feat_index = bank*200 + addr.
REQ-014 SHALL issue at most one read per cycle, only in READ, and only when (FIFO occupancy + in-flight reads) < FIFO_DEPTH; the address holds otherwise.
REQ-015 SHALL track in-flight reads with a READ_LATENCY-deep valid/bank/index shift register; the returning word is pushed into the FIFO exactly READ_LATENCY cycles after its address is presented.
REQ-016 SHALL present the FIFO head combinationally (show-ahead) on feat_data/feat_index with feat_valid = FIFO not empty.
REQ-017 SHALL complete a beat on a cycle with feat_valid=1 and feat_ready=1; feat_data/feat_index SHALL remain stable while feat_valid=1 and feat_ready=0.
REQ-018 SHALL allow simultaneous push and pop in one cycle, including when the FIFO is full or empty; the FIFO SHALL never overflow (guaranteed by REQ-014) nor pop when empty.
REQ-019 SHALL wrap the address counter from 199 to 0 when switching phase A to B, without a bubble.
REQ-020 SHALL sustain 1 beat per cycle with feat_ready held high.
REQ-021 SHALL keep L4_output_read_addr at 0 outside READ.
REQ-022 SHALL count accepted beats (9 bits); DRAIN->DONE on acceptance of index 399.

Reset
REQ-023 SHALL, on rst=0 at any time (including mid-READ), asynchronously force: state IDLE, L4_output_read_addr=0, FIFO empty, pipeline valid bits 0, counters 0, feat_valid=0, feat_data=0, feat_index=0, L4_done=0.
REQ-024 SHALL resume only from IDLE after rst returns high; a held-high L4_en SHALL start a fresh readout from index 0.

Verification
REQ-025 SHALL verify streaming: bank1[a]=a, bank2[a]=0x800+a, feat_ready=1, L4_en raised -> first feat_valid 4 cycles after L4_en sampled, 400 consecutive beats, index 0..399, data 0..199 then 0x800..0x8C7, L4_done next cycle after beat 399.
REQ-026 SHALL verify backpressure: feat_ready random 30% -> identical data sequence, data stable while stalled, FIFO occupancy never > 4, no address advance while credit exhausted.
REQ-027 SHALL verify phase boundary: addr 199 (bank1) followed by addr 0 (bank2) on consecutive cycles; beats 199/200 carry bank1[199], bank2[0].
REQ-028 SHALL verify abort: L4_en dropped at beat 150 -> state IDLE next cycle, feat_valid 0, re-raise restarts at index 0.
REQ-029 SHALL verify async reset mid-READ (asserted between clock edges): all outputs 0 immediately, no beat after reset release until L4_en re-sampled.
REQ-030 SHALL verify DONE hold: L4_en kept high after completion -> L4_done stays 1, no further reads; L4_en low -> IDLE, L4_done 0.

Source files
------------

// File: rtl/l4_feature_reader.sv
// Layer-4 feature reader: walks both L4 output banks (400 words) through a credit-limited
// read pipeline into a show-ahead FIFO, presented on a valid/ready stream.
module l4_feature_reader #(
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned CHANNEL_SIZE = 25,
    parameter int unsigned BANK_DEPTH   = 200,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  L4_en,
    output logic [7:0]            L4_output_read_addr,
    input  logic [DATA_WIDTH-1:0] L4_output_read_data1,
    input  logic [DATA_WIDTH-1:0] L4_output_read_data2,
    output logic                  feat_valid,
    input  logic                  feat_ready,
    output logic [DATA_WIDTH-1:0] feat_data,
    output logic [8:0]            feat_index,
    output logic                  L4_done
);
    // A bank holds 8 channels; never walk past the physical bank depth.
    localparam int unsigned BankWords  = (8 * CHANNEL_SIZE < BANK_DEPTH) ? 8 * CHANNEL_SIZE
                                                                         : BANK_DEPTH;
    localparam int unsigned TotalWords = 2 * BankWords;
    localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0]  LastAddr   = 8'(BankWords - 1);
    localparam logic [8:0]  LastIdx    = 9'(TotalWords - 1);
    localparam logic [8:0]  BankBase   = 9'(BankWords);

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StRead  = 4'b0010,
        StDrain = 4'b0100,
        StDone  = 4'b1000
    } state_e;

    state_e state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic       bank_q, bank_d;
    logic [8:0] acc_q, acc_d;

    logic [READ_LATENCY-1:0] pipe_valid_q;
    logic [READ_LATENCY-1:0] pipe_bank_q;
    logic [8:0]              pipe_idx_q [READ_LATENCY];

    logic [DATA_WIDTH+8:0] fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic                  issue, flush, push, pop;
    logic [8:0]            issue_idx;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH+8:0] head;
    int unsigned           outstanding;

    // Credit: words already buffered plus words still in the memory pipeline.
    always_comb begin
        outstanding = 32'(cnt_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            outstanding = outstanding + 32'(pipe_valid_q[i]);
        end
    end

    assign issue     = (state_q == StRead) && (outstanding < FIFO_DEPTH);
    assign issue_idx = (bank_q ? BankBase : 9'd0) + {1'b0, addr_q};
    assign push      = pipe_valid_q[READ_LATENCY-1];
    assign push_data = pipe_bank_q[READ_LATENCY-1] ? L4_output_read_data2 : L4_output_read_data1;
    assign pop       = feat_valid && feat_ready;
    assign cnt_d     = cnt_q + CntW'(push) - CntW'(pop);

    assign head       = fifo_mem[rd_ptr_q];
    assign feat_valid = (cnt_q != '0);
    assign feat_data  = feat_valid ? head[DATA_WIDTH-1:0] : '0;
    assign feat_index = feat_valid ? head[DATA_WIDTH+8:DATA_WIDTH] : '0;

    assign L4_output_read_addr = (state_q == StRead) ? addr_q : '0;
    assign L4_done             = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        addr_d  = addr_q;
        bank_d  = bank_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle: if (L4_en) state_d = StRead;
            StRead: begin
                if (!L4_en) begin
                    state_d = StIdle;
                    flush   = 1'b1;
                end else if (issue && bank_q && (addr_q == LastAddr)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!L4_en) begin
                    state_d = StIdle;
                    flush   = 1'b1;
                end else if (pop && (acc_q == LastIdx)) begin
                    state_d = StDone;
                end
            end
            StDone: if (!L4_en) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if ((state_q == StIdle) || flush) begin
            addr_d = '0;
            bank_d = 1'b0;
            acc_d  = '0;
        end else begin
            if (issue) begin
                if (addr_q == LastAddr) begin
                    addr_d = '0;
                    bank_d = ~bank_q;
                end else begin
                    addr_d = addr_q + 8'd1;
                end
            end
            if (pop) acc_d = acc_q + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            bank_q       <= 1'b0;
            acc_q        <= '0;
            pipe_valid_q <= '0;
            pipe_bank_q  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_idx_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            acc_q   <= acc_d;
            if (flush) begin
                pipe_valid_q <= '0;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                cnt_q        <= '0;
            end else begin
                pipe_valid_q[0] <= issue;
                pipe_bank_q[0]  <= bank_q;
                pipe_idx_q[0]   <= issue_idx;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    pipe_valid_q[i] <= pipe_valid_q[i-1];
                    pipe_bank_q[i]  <= pipe_bank_q[i-1];
                    pipe_idx_q[i]   <= pipe_idx_q[i-1];
                end
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
                cnt_q <= cnt_d;
            end
        end
    end

    // Storage needs no reset: nothing is visible until the count says so.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {pipe_idx_q[READ_LATENCY-1], push_data};
    end

endmodule
